// File: rtl/send_pkt_demux_pkg.sv
// Default sizing for the send-packet demux and its per-destination FIFOs.
package send_pkt_demux_pkg;

  localparam int DEMUX_NUM_DSTS_DEF   = 2;
  localparam int DEMUX_FIFO_DEPTH_DEF = 4;

  // Occupancy must represent 0..depth inclusive, hence the extra bit.
  function automatic int occ_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/tcp_misc_pkg.sv
// Shared TCP slow-path types. Only the send-packet request record is
// needed by the demux.
package tcp_misc_pkg;

  typedef struct packed {
    logic [15:0] flow_id;
    logic [31:0] seq_num;
    logic [15:0] payload_len;
  } send_pkt_struct;

  localparam int SEND_PKT_STRUCT_W = $bits(send_pkt_struct);

endpackage

// File: rtl/send_pkt_demux_chk.sv
// Simulation-only checks on the demux input stream.
module send_pkt_demux_chk #(
  parameter int NUM_DSTS = 2,
  parameter int DST_W    = 1
) (
  input logic             clk_i,
  input logic             rst_ni,
  input logic             val_i,
  input logic [DST_W-1:0] dst_i
);

  // Flag any valid beat steered at a destination that does not exist.
  always_ff @(posedge clk_i) begin
    if (rst_ni && val_i) begin
      assert (int'(dst_i) < NUM_DSTS)
        else $error("send_pkt_demux: destination index %0d out of range", dst_i);
    end
  end

endmodule

// File: rtl/send_pkt_demux_fifo.sv
// Single-clock FIFO with occupancy output; full/empty derive from the
// counter so the pointers can wrap freely.
module send_pkt_demux_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [W-1:0]     data_i,
  input  logic             pop_i,
  output logic [W-1:0]     data_o,
  output logic             val_o,
  output logic             full_o,
  output logic [CNT_W-1:0] occ_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             push_s, pop_s;

  assign full_o = (occ_q == CNT_W'(DEPTH));
  assign val_o  = (occ_q != CNT_W'(0));
  assign occ_o  = occ_q;
  assign data_o = mem_q[rd_ptr_q];

  // A full FIFO refuses a push even when it pops in the same cycle.
  assign push_s = push_i & ~full_o;
  assign pop_s  = pop_i & val_o;

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   occ_d = occ_q + CNT_W'(1);
      2'b01:   occ_d = occ_q - CNT_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Payload storage; contents are don't-care until the counter covers them.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/send_pkt_demux.sv
// Fans one send_pkt_struct request stream out to NUM_DSTS per-engine
// FIFOs, steered by a per-beat destination index.
module send_pkt_demux
  import tcp_misc_pkg::*;
  import send_pkt_demux_pkg::*;
#(
  parameter int NUM_DSTS   = DEMUX_NUM_DSTS_DEF,
  parameter int DST_W      = $clog2(NUM_DSTS),
  parameter int FIFO_DEPTH = DEMUX_FIFO_DEPTH_DEF,
  parameter int CNT_W      = occ_cnt_w(FIFO_DEPTH)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  src_demux_val,
  input  logic [SEND_PKT_STRUCT_W-1:0]          src_demux_data,
  input  logic [DST_W-1:0]                      src_demux_dst,
  output logic                                  demux_src_rdy,
  output logic [NUM_DSTS-1:0]                   demux_dst_val,
  output logic [NUM_DSTS*SEND_PKT_STRUCT_W-1:0] demux_dst_data,
  input  logic [NUM_DSTS-1:0]                   dst_demux_rdy,
  output logic [NUM_DSTS*CNT_W-1:0]             demux_dst_occ
);

  logic                active_q;
  logic                accept_s;
  logic [NUM_DSTS-1:0] dst_match_s;
  logic [NUM_DSTS-1:0] full_s;
  logic [NUM_DSTS-1:0] push_s;
  logic [NUM_DSTS-1:0] pop_s;

  // Holds rdy low during reset and releases it on the first edge after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
    end else begin
      active_q <= 1'b1;
    end
  end

  // An index matching no destination keeps rdy high and pushes nowhere.
  assign demux_src_rdy = active_q & ~|(dst_match_s & full_s);
  assign accept_s      = src_demux_val & demux_src_rdy;

  for (genvar g = 0; g < NUM_DSTS; g++) begin : g_dst
    assign dst_match_s[g] = (src_demux_dst == DST_W'(g));
    assign push_s[g]      = accept_s & dst_match_s[g];
    assign pop_s[g]       = demux_dst_val[g] & dst_demux_rdy[g];

    send_pkt_demux_fifo #(
      .W     (SEND_PKT_STRUCT_W),
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
    ) u_fifo (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .push_i (push_s[g]),
      .data_i (src_demux_data),
      .pop_i  (pop_s[g]),
      .data_o (demux_dst_data[g*SEND_PKT_STRUCT_W +: SEND_PKT_STRUCT_W]),
      .val_o  (demux_dst_val[g]),
      .full_o (full_s[g]),
      .occ_o  (demux_dst_occ[g*CNT_W +: CNT_W])
    );
  end

  send_pkt_demux_chk #(
    .NUM_DSTS (NUM_DSTS),
    .DST_W    (DST_W)
  ) u_chk (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .val_i  (src_demux_val),
    .dst_i  (src_demux_dst)
  );

endmodule

// File: tb/tb_send_pkt_demux.sv
// Directed and scoreboarded checks of send_pkt_demux with two destinations
// and four-entry FIFOs.
module tb_send_pkt_demux;
  import tcp_misc_pkg::*;

  localparam int NUM_DSTS = 2;
  localparam int DST_W    = 1;
  localparam int DEPTH    = 4;
  localparam int CNT_W    = 3;
  localparam int W        = SEND_PKT_STRUCT_W;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  src_demux_val;
  logic [W-1:0]          src_demux_data;
  logic [DST_W-1:0]      src_demux_dst;
  logic                  demux_src_rdy;
  logic [NUM_DSTS-1:0]   demux_dst_val;
  logic [NUM_DSTS*W-1:0] demux_dst_data;
  logic [NUM_DSTS-1:0]   dst_demux_rdy;
  logic [NUM_DSTS*CNT_W-1:0] demux_dst_occ;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  send_pkt_demux #(
    .NUM_DSTS   (NUM_DSTS),
    .DST_W      (DST_W),
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .src_demux_val  (src_demux_val),
    .src_demux_data (src_demux_data),
    .src_demux_dst  (src_demux_dst),
    .demux_src_rdy  (demux_src_rdy),
    .demux_dst_val  (demux_dst_val),
    .demux_dst_data (demux_dst_data),
    .dst_demux_rdy  (dst_demux_rdy),
    .demux_dst_occ  (demux_dst_occ)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] dat(input int i);
    return 64'(demux_dst_data[i*W +: W]);
  endfunction

  function automatic logic [63:0] occ(input int i);
    return 64'(demux_dst_occ[i*CNT_W +: CNT_W]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int d, input logic [63:0] data);
    src_demux_val  = v;
    src_demux_dst  = DST_W'(d);
    src_demux_data = W'(data);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] q0[$];
    logic [63:0] q1[$];
    logic [63:0] cur_data;
    logic        exp_rdy;
    int          cur_dst;
    int          acc_cnt;
    int          cyc;

    // Reset and idle
    rst_n = 1'b0;
    dst_demux_rdy = 2'b11;
    drive(1'b0, 0, 64'h0);
    tick();
    tick();
    chk("rst_rdy", 64'(demux_src_rdy), 64'd0);
    chk("rst_val", 64'(demux_dst_val), 64'd0);
    chk("rst_occ", 64'(demux_dst_occ), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_rdy", 64'(demux_src_rdy), 64'd1);
    chk("idle_val", 64'(demux_dst_val), 64'd0);
    chk("idle_occ", 64'(demux_dst_occ), 64'd0);

    // Steering 0,1,1,0 with A,B,C,D
    drive(1'b1, 0, 64'hAAAA_0000_0000_000A);
    tick();
    chk("steer_a_val", 64'(demux_dst_val), 64'd1);
    chk("steer_a_dat", dat(0), 64'hAAAA_0000_0000_000A);
    drive(1'b1, 1, 64'hBBBB_0000_0000_000B);
    tick();
    chk("steer_b_val", 64'(demux_dst_val), 64'd2);
    chk("steer_b_dat", dat(1), 64'hBBBB_0000_0000_000B);
    drive(1'b1, 1, 64'hCCCC_0000_0000_000C);
    tick();
    chk("steer_c_val", 64'(demux_dst_val), 64'd2);
    chk("steer_c_dat", dat(1), 64'hCCCC_0000_0000_000C);
    drive(1'b1, 0, 64'hDDDD_0000_0000_000D);
    tick();
    chk("steer_d_val", 64'(demux_dst_val), 64'd1);
    chk("steer_d_dat", dat(0), 64'hDDDD_0000_0000_000D);
    drive(1'b0, 0, 64'h0);
    tick();
    chk("steer_drain_val", 64'(demux_dst_val), 64'd0);
    chk("steer_drain_occ", 64'(demux_dst_occ), 64'd0);

    // Fill FIFO0 with E0..E3 while out0 is stalled
    dst_demux_rdy = 2'b10;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 0, 64'hE000 + 64'(k));
      chk("fill_rdy", 64'(demux_src_rdy), 64'd1);
      tick();
    end
    chk("full_occ0", occ(0), 64'd4);
    drive(1'b1, 0, 64'hE004);
    chk("full_rdy", 64'(demux_src_rdy), 64'd0);
    tick();
    chk("full_hold_occ0", occ(0), 64'd4);
    chk("full_head", dat(0), 64'hE000);
    // One pop frees a slot; the stalled beat goes in a cycle later
    dst_demux_rdy = 2'b11;
    tick();
    dst_demux_rdy = 2'b10;
    #1;
    chk("pop1_occ0", occ(0), 64'd3);
    chk("pop1_rdy", 64'(demux_src_rdy), 64'd1);
    tick();
    chk("e4_occ0", occ(0), 64'd4);

    // Head-of-line: E5 stalls on FIFO0, nothing reaches out1
    drive(1'b1, 0, 64'hE005);
    tick();
    tick();
    chk("hol_rdy", 64'(demux_src_rdy), 64'd0);
    chk("hol_val1", 64'(demux_dst_val[1]), 64'd0);
    chk("hol_occ1", occ(1), 64'd0);
    chk("hol_head0", dat(0), 64'hE001);
    dst_demux_rdy = 2'b11;
    tick();
    chk("hol_pop_occ0", occ(0), 64'd3);
    chk("hol_pop_head", dat(0), 64'hE002);
    tick();
    chk("hol_e5_occ0", occ(0), 64'd3);
    chk("hol_e5_head", dat(0), 64'hE003);
    drive(1'b1, 1, 64'hF00F);
    tick();
    chk("hol_f_occ0", occ(0), 64'd2);
    chk("hol_f_occ1", occ(1), 64'd1);
    chk("hol_f_dat1", dat(1), 64'hF00F);
    drive(1'b0, 0, 64'h0);
    tick();
    chk("hol_tail_head", dat(0), 64'hE005);
    chk("hol_tail_occ", 64'(demux_dst_occ), 64'({3'd0, 3'd1}));
    tick();
    chk("hol_empty_val", 64'(demux_dst_val), 64'd0);

    // Concurrent push/pop on out1 at occ1 = 2
    dst_demux_rdy = 2'b00;
    drive(1'b1, 1, 64'h6000);
    tick();
    drive(1'b1, 1, 64'h6001);
    tick();
    chk("cc_pre_occ1", occ(1), 64'd2);
    dst_demux_rdy = 2'b10;
    drive(1'b1, 1, 64'h6002);
    tick();
    chk("cc_occ1", occ(1), 64'd2);
    chk("cc_head1", dat(1), 64'h6001);
    drive(1'b0, 0, 64'h0);
    tick();
    chk("cc_next_head1", dat(1), 64'h6002);
    chk("cc_next_occ1", occ(1), 64'd1);
    tick();
    chk("cc_empty_val", 64'(demux_dst_val), 64'd0);

    // Random traffic against a per-destination scoreboard
    acc_cnt  = 0;
    cyc      = 0;
    cur_dst  = $urandom_range(0, 1);
    cur_data = {$urandom, $urandom};
    while (acc_cnt < 20 && cyc < 200) begin
      cyc++;
      dst_demux_rdy = 2'($urandom_range(0, 3));
      drive(1'b1, cur_dst, cur_data);
      exp_rdy = (cur_dst == 0) ? (q0.size() < DEPTH) : (q1.size() < DEPTH);
      chk("rnd_rdy", 64'(demux_src_rdy), 64'(exp_rdy));
      if (q0.size() > 0 && dst_demux_rdy[0]) void'(q0.pop_front());
      if (q1.size() > 0 && dst_demux_rdy[1]) void'(q1.pop_front());
      if (exp_rdy) begin
        if (cur_dst == 0) q0.push_back(cur_data);
        else q1.push_back(cur_data);
      end
      tick();
      chk("rnd_occ0", occ(0), 64'(q0.size()));
      chk("rnd_occ1", occ(1), 64'(q1.size()));
      chk("rnd_val", 64'(demux_dst_val), 64'({q1.size() != 0, q0.size() != 0}));
      if (q0.size() > 0) chk("rnd_dat0", dat(0), q0[0]);
      if (q1.size() > 0) chk("rnd_dat1", dat(1), q1[0]);
      if (exp_rdy) begin
        acc_cnt++;
        cur_dst  = $urandom_range(0, 1);
        cur_data = {$urandom, $urandom};
      end
    end
    chk("rnd_accepted", 64'(acc_cnt), 64'd20);
    dst_demux_rdy = 2'b11;
    drive(1'b0, 0, 64'h0);
    for (int k = 0; k < 5; k++) tick();
    chk("rnd_drained", 64'(demux_dst_occ), 64'd0);

    // Async reset with occ0 = 3, occ1 = 1
    dst_demux_rdy = 2'b00;
    drive(1'b1, 0, 64'h7000);
    tick();
    drive(1'b1, 0, 64'h7001);
    tick();
    drive(1'b1, 0, 64'h7002);
    tick();
    drive(1'b1, 1, 64'h7100);
    tick();
    drive(1'b0, 0, 64'h0);
    chk("pre_rst_occ", 64'(demux_dst_occ), 64'({3'd1, 3'd3}));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_val", 64'(demux_dst_val), 64'd0);
    chk("arst_occ", 64'(demux_dst_occ), 64'd0);
    chk("arst_rdy", 64'(demux_src_rdy), 64'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    dst_demux_rdy = 2'b11;
    tick();
    chk("post_rst_rdy", 64'(demux_src_rdy), 64'd1);
    for (int k = 0; k < 3; k++) begin
      chk("post_rst_no_stale", 64'(demux_dst_val), 64'd0);
      tick();
    end
    drive(1'b1, 1, 64'h8888);
    tick();
    drive(1'b0, 0, 64'h0);
    chk("post_rst_val", 64'(demux_dst_val), 64'd2);
    chk("post_rst_dat1", dat(1), 64'h8888);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/send_pkt_demux.md
Name: send_pkt_demux

Overview:
- Splits one send_pkt_struct request stream into NUM_DSTS destination streams; each request is steered by a per-beat destination index.
- Inverse of the round-robin send-packet merge in the TCP slow path: the merge collapses engines into one stream, this block fans one stream back out to per-engine consumers.
- Each output has its own FIFO. A stalled destination blocks the input only when a beat targets that destination's full FIFO.

Parameters:
- NUM_DSTS, 2, number of destination streams; must be ≥2.
- DST_W, $clog2(NUM_DSTS), width of the destination index.
- FIFO_DEPTH, 4, entries per output FIFO; must be a power of two and ≥2.
- CNT_W, $clog2(FIFO_DEPTH)+1, width of the occupancy counters.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- src_demux_val  in  1  input beat valid.
- src_demux_data  in  SEND_PKT_STRUCT_W  send_pkt_struct payload.
- src_demux_dst  in  DST_W  destination index; meaningful only when val is high.
- demux_src_rdy  out  1  input ready.
- demux_dst_val  out  NUM_DSTS  per-destination valid, bit i belongs to destination i.
- demux_dst_data  out  NUM_DSTS*SEND_PKT_STRUCT_W  packed payloads, destination i at slice i.
- dst_demux_rdy  in  NUM_DSTS  per-destination ready.
- demux_dst_occ  out  NUM_DSTS*CNT_W  per-FIFO occupancy, for debug and performance counters.

Behaviour:
- Reset: asserting rst_n low asynchronously clears all FIFO pointers and occupancies. While in reset:
  - demux_dst_val = 0
  - demux_src_rdy = 0
  - demux_dst_occ = 0
  - demux_dst_data is don't-care.
- After reset: demux_src_rdy goes high in the first cycle after rst_n deasserts, provided the targeted FIFO is not full.
- Ready: demux_src_rdy = ~full[src_demux_dst]. It is computed from registered state only and never depends on dst_demux_rdy.
- Accept: a beat is accepted when src_demux_val & demux_src_rdy. Accept pushes src_demux_data into FIFO[src_demux_dst].
  - src_demux_dst ≥ NUM_DSTS: rdy = 1 and the beat is silently dropped. Simulation asserts an error.
- Output: demux_dst_val[i] = ~empty[i]; demux_dst_data slice i = FIFO[i] head.
- Pop: FIFO[i] pops when demux_dst_val[i] & dst_demux_rdy[i].
- Latency: minimum 1 cycle from input accept to demux_dst_val. There is no combinational bypass.
- Throughput: one input beat per cycle. Each output can pop one beat per cycle, concurrently with the other outputs.
- Ordering: FIFO order is strict per destination. There is no ordering guarantee across destinations.
- Full: a push into a full FIFO is not allowed, even if that FIFO pops in the same cycle. This costs one bubble but keeps the rdy path registered.
- Simultaneous push and pop on the same FIFO (not full): both take effect and the occupancy is unchanged.
- Empty: a push into an empty FIFO makes val visible the next cycle; there is no same-cycle passthrough.
- Wrap: read and write pointers wrap modulo FIFO_DEPTH. Full/empty come from the occupancy counter, range 0..FIFO_DEPTH.
- Head-of-line: a beat stalled on a full destination blocks all later input beats. This is intended; no reordering is done.
- Stability: the upstream holds val, data and dst stable until accept. The block does not sample on a non-accepted cycle.
- Reset mid-operation: all queued beats are discarded and the outputs return to their reset values immediately.

Decomposition:
- send_pkt_struct and SEND_PKT_STRUCT_W stay in tcp_misc_pkg.
- No new typedefs are needed. DST_W is derived locally.
- One sub-module, send_pkt_demux_fifo: a single-clock FIFO, FIFO_DEPTH deep, SEND_PKT_STRUCT_W wide, with an occupancy output.
  - Its reset is async active-low.
  - It is instantiated NUM_DSTS times.
  - The top level holds only the decode of src_demux_dst into push enables and the rdy select.

Test Plan:
- Reset/idle: hold rst_n low, release it, no traffic -> cycle 1 after release: rdy = 1, all val = 0, all occ = 0.
- Steering: 4 beats, dst sequence 0,1,1,0, payloads A,B,C,D, all dst rdy = 1 -> out0 sees A then D, out1 sees B then C, each 1 cycle after its accept.
- Full/backpressure: dst_rdy[0] = 0, 5 beats to dst 0 -> first 4 accepted, occ0 = 4, rdy = 0 on the 5th. Raise dst_rdy[0] for one cycle -> occ0 = 3, rdy = 1 next cycle, 5th beat accepted.
- Head-of-line blocking: FIFO0 full, next beat targets dst 1 -> it is blocked behind the dst-0 beat; out1 stays idle until FIFO0 pops.
- Concurrent push/pop: occ1 = 2, push to dst 1 and pop out1 in the same cycle -> occ1 stays 2, order preserved. Over 20 random beats, FIFO wrap is checked against a scoreboard.
- Async reset mid-stream: drop rst_n with occ0 = 3 and occ1 = 1, not aligned to clk -> all val and occ go to 0 immediately. After release, no stale beats appear.
